// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared sizes and receiver state encoding for the serial sample link.
package serial_link_pkg;
    localparam int BYTE_W   = 8;
    localparam int GAP_MAX  = 16;
    localparam int SAMPLE_W = 2 * BYTE_W;
    typedef enum logic [1:0] {IDLE, HI_SHIFT, GAP_WAIT, LO_SHIFT} state_e;
endpackage

// File: rtl/shift_in_reg.sv
// shift_in_reg: enable-gated MSB-first byte shifter with bit counter and last-bit done pulse.
module shift_in_reg
    import serial_link_pkg::*;
#(
    parameter int BYTE_W = serial_link_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              shift,
    input  logic              si,
    output logic [BYTE_W-1:0] data,
    output logic              done
);
    localparam int CNT_W = $clog2(BYTE_W + 1);
    logic [BYTE_W-2:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // data already includes the bit being sampled this cycle, so done can latch it directly
    assign data = {shreg_q, si};
    assign done = en & shift & (cnt_q == CNT_W'(BYTE_W - 1));
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (en) begin
            shreg_d = clr ? '0 : shift ? data[BYTE_W-2:0] : shreg_q;
            cnt_d   = (clr | done) ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/serial_sample_receiver.sv
// serial_sample_receiver: rebuilds 16-bit samples from two MSB-first serial bytes,
// flagging framing violations and strobing each completed sample.
module serial_sample_receiver
    import serial_link_pkg::*;
#(
    parameter int BYTE_W  = serial_link_pkg::BYTE_W,
    parameter int GAP_MAX = serial_link_pkg::GAP_MAX
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                si,
    input  logic                byte_start,
    input  logic                sample_start,
    output logic [2*BYTE_W-1:0] sample,
    output logic                sample_valid,
    output logic                frame_err,
    output logic                busy
);
    localparam int GAP_W = $clog2(GAP_MAX + 1);
    state_e              state_q, state_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [BYTE_W-1:0]   hi_q, hi_d, data;
    logic [2*BYTE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d, err_q, err_d, busy_q, busy_d;
    logic                in_shift, done, b2b;
    assign in_shift = (state_q == HI_SHIFT) | (state_q == LO_SHIFT);
    // a new high byte starting on the last low bit completes the sample without error
    assign b2b      = (state_q == LO_SHIFT) & done & sample_start;
    shift_in_reg #(.BYTE_W(BYTE_W)) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (byte_start),
        .shift (in_shift),
        .si    (si),
        .data  (data),
        .done  (done)
    );
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        hi_d     = hi_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: if (byte_start) begin
                    state_d = sample_start ? HI_SHIFT : IDLE;
                    err_d   = !sample_start;
                end
                GAP_WAIT: if (byte_start) begin
                    state_d = sample_start ? HI_SHIFT : LO_SHIFT;
                    err_d   = sample_start;
                end else if (gap_q == GAP_W'(GAP_MAX)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
                default: if (byte_start) begin
                    state_d  = sample_start ? HI_SHIFT : IDLE;
                    valid_d  = b2b;
                    err_d    = !b2b;
                    sample_d = b2b ? {hi_q, data} : sample_q;
                end else if (done) begin
                    state_d  = (state_q == HI_SHIFT) ? GAP_WAIT : IDLE;
                    hi_d     = (state_q == HI_SHIFT) ? data : hi_q;
                    gap_d    = '0;
                    valid_d  = (state_q == LO_SHIFT);
                    sample_d = (state_q == LO_SHIFT) ? {hi_q, data} : sample_q;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            hi_q     <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            hi_q     <= hi_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_serial_sample_receiver.sv
// tb_serial_sample_receiver: directed and randomized frames checked against a
// transaction-level model of the serial sample link.
module tb_serial_sample_receiver;
    localparam int GAP_MAX = 16;
    logic        clk = 1'b0;
    logic        rst_n, en, si, byte_start, sample_start;
    logic [15:0] sample;
    logic        sample_valid, frame_err, busy;
    int          n_assert = 0, n_fail = 0, wall = 0, n_valid, n_err, t0, g;
    logic [15:0] got[$];
    int          vat[$];
    logic [15:0] exp_sample;
    logic [7:0]  hi, lo;

    serial_sample_receiver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .si           (si),
        .byte_start   (byte_start),
        .sample_start (sample_start),
        .sample       (sample),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic clear_obs();
        n_valid = 0;
        n_err   = 0;
        got.delete();
        vat.delete();
    endtask

    // one clock with given inputs; outputs read 1 time unit after the edge belong to cycle wall
    task automatic cyc(input logic e, input logic bs, input logic ss, input logic s);
        en = e; byte_start = bs; sample_start = ss; si = s;
        @(posedge clk);
        #1;
        wall++;
        if (sample_valid) begin
            n_valid++;
            got.push_back(sample);
            vat.push_back(wall);
        end
        if (frame_err) n_err++;
        if (!e) chk("en0_pulses", 32'({sample_valid, frame_err}), 32'd0);
    endtask

    task automatic strobe(input logic ss);
        cyc(1'b1, 1'b1, ss, 1'($urandom));
    endtask

    task automatic send_bits(input logic [7:0] b, input logic lbs, input logic lss);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, i == 7 ? lbs : 1'b0, i == 7 ? lss : 1'b0, b[7-i]);
    endtask

    task automatic gap_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'($urandom));
    endtask

    function automatic logic [31:0] first_got(input int idx);
        return (got.size() > idx) ? 32'(got[idx]) : 32'hdead_beef;
    endfunction

    function automatic int first_vat(input int idx);
        return (vat.size() > idx) ? vat[idx] : -1;
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b0; si = 1'b1; byte_start = 1'b0; sample_start = 1'b0;
        exp_sample = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // frames with random data and gaps; gaps beyond GAP_MAX time out, then the low byte is an orphan
        for (int k = 0; k < 8; k++) begin
            hi = (k == 0) ? 8'hA5 : 8'($urandom);
            lo = (k == 0) ? 8'h3C : 8'($urandom);
            g  = (k == 0) ? 7 : (k == 1) ? GAP_MAX : (k == 2) ? 0 : (k == 3) ? GAP_MAX + 1
               : int'($urandom_range(0, GAP_MAX + 3));
            clear_obs();
            strobe(1'b1);
            send_bits(hi, 1'b0, 1'b0);
            gap_cycles(g);
            t0 = wall;
            strobe(1'b0);
            send_bits(lo, 1'b0, 1'b0);
            gap_cycles(1);
            if (g <= GAP_MAX) begin
                exp_sample = {hi, lo};
                chk("frame_valid_cnt", 32'(n_valid), 32'd1);
                chk("frame_latency", 32'(first_vat(0)), 32'(t0 + 9));
                chk("frame_err_cnt", 32'(n_err), 32'd0);
            end else begin
                chk("gap_err_cnt", 32'(n_err), 32'd2);
                chk("gap_valid_cnt", 32'(n_valid), 32'd0);
            end
            chk("frame_sample", 32'(sample), 32'(exp_sample));
            chk("frame_busy", 32'(busy), 32'd0);
        end

        // gap timeout exactly at GAP_MAX
        clear_obs();
        strobe(1'b1);
        send_bits(8'hFF, 1'b0, 1'b0);
        gap_cycles(GAP_MAX);
        chk("gap16_no_err_yet", 32'(n_err), 32'd0);
        chk("gap16_busy", 32'(busy), 32'd1);
        gap_cycles(1);
        chk("gap17_err", 32'(n_err), 32'd1);
        chk("gap17_busy", 32'(busy), 32'd0);
        chk("gap17_sample", 32'(sample), 32'(exp_sample));
        chk("gap17_valid", 32'(n_valid), 32'd0);

        // back-to-back samples
        clear_obs();
        strobe(1'b1);
        send_bits(8'h12, 1'b0, 1'b0);
        strobe(1'b0);
        send_bits(8'h34, 1'b1, 1'b1);
        send_bits(8'hBE, 1'b0, 1'b0);
        strobe(1'b0);
        send_bits(8'hEF, 1'b0, 1'b0);
        gap_cycles(1);
        exp_sample = 16'hBEEF;
        chk("b2b_valid_cnt", 32'(n_valid), 32'd2);
        chk("b2b_err_cnt", 32'(n_err), 32'd0);
        chk("b2b_first", first_got(0), 32'h1234);
        chk("b2b_second", first_got(1), 32'hBEEF);
        chk("b2b_spacing", 32'(first_vat(1) - first_vat(0)), 32'd17);

        // enable dropped for 5 cycles mid low byte, with noise on the strobes
        clear_obs();
        lo = 8'hFF;
        strobe(1'b1);
        send_bits(8'h00, 1'b0, 1'b0);
        gap_cycles(3);
        t0 = wall;
        strobe(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) repeat (5) cyc(1'b0, 1'b1, 1'($urandom), 1'($urandom));
            cyc(1'b1, 1'b0, 1'b0, lo[7-i]);
        end
        gap_cycles(1);
        exp_sample = 16'h00FF;
        chk("stall_sample", 32'(sample), 32'h00FF);
        chk("stall_latency", 32'(first_vat(0)), 32'(t0 + 14));
        chk("stall_valid_cnt", 32'(n_valid), 32'd1);
        chk("stall_err_cnt", 32'(n_err), 32'd0);

        // asynchronous reset at bit 4 of the low byte
        strobe(1'b1);
        send_bits(8'h77, 1'b0, 1'b0);
        strobe(1'b0);
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'($urandom));
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sample", 32'(sample), 32'd0);
        chk("async_rst_valid", 32'(sample_valid), 32'd0);
        chk("async_rst_err", 32'(frame_err), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_obs();
        strobe(1'b1);
        send_bits(8'h80, 1'b0, 1'b0);
        strobe(1'b0);
        send_bits(8'h01, 1'b0, 1'b0);
        gap_cycles(1);
        exp_sample = 16'h8001;
        chk("post_rst_sample", 32'(sample), 32'h8001);
        chk("post_rst_valid_cnt", 32'(n_valid), 32'd1);
        chk("post_rst_err_cnt", 32'(n_err), 32'd0);

        // orphan low byte, then a restart at bit 3 of a high byte
        clear_obs();
        strobe(1'b0);
        gap_cycles(2);
        chk("orphan_err", 32'(n_err), 32'd1);
        chk("orphan_busy", 32'(busy), 32'd0);
        strobe(1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'($urandom));
        strobe(1'b1);
        send_bits(8'h5A, 1'b0, 1'b0);
        gap_cycles(2);
        strobe(1'b0);
        send_bits(8'h5A, 1'b0, 1'b0);
        gap_cycles(1);
        exp_sample = 16'h5A5A;
        chk("restart_err_cnt", 32'(n_err), 32'd2);
        chk("restart_valid_cnt", 32'(n_valid), 32'd1);
        chk("restart_sample", 32'(sample), 32'h5A5A);

        // premature low-byte start drops the sample and returns to idle
        clear_obs();
        strobe(1'b1);
        send_bits(8'($urandom), 1'b0, 1'b0);
        strobe(1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'($urandom));
        strobe(1'b0);
        gap_cycles(1);
        chk("premature_err", 32'(n_err), 32'd1);
        chk("premature_busy", 32'(busy), 32'd0);
        chk("premature_valid", 32'(n_valid), 32'd0);
        chk("premature_sample", 32'(sample), 32'(exp_sample));

        // new sample_start while waiting for the low byte restarts the frame
        clear_obs();
        strobe(1'b1);
        send_bits(8'($urandom), 1'b0, 1'b0);
        gap_cycles(2);
        strobe(1'b1);
        send_bits(8'hC3, 1'b0, 1'b0);
        strobe(1'b0);
        send_bits(8'h96, 1'b0, 1'b0);
        gap_cycles(1);
        chk("gap_restart_err", 32'(n_err), 32'd1);
        chk("gap_restart_valid", 32'(n_valid), 32'd1);
        chk("gap_restart_sample", 32'(sample), 32'hC396);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
